// File: rtl/ads1672_capture_sched.sv
// ads1672_capture_sched: ADC measure scheduler with data timeout, 2^n block averaging and a valid/ready result stream.
// Optional m_seq result tag when ADS_SCHED_SEQ_TAG_EN is defined.
module ads1672_capture_sched #(
  parameter int DATA_WIDTH     = 24,
  parameter int PERIOD_WIDTH   = 24,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int AVG_LOG2_MAX   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic [2:0]              avg_log2,
  output logic                    adc_measure,
  input  logic                    adc_valid,
  input  logic [DATA_WIDTH-1:0]   adc_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [15:0]             overrun_cnt
`ifdef ADS_SCHED_SEQ_TAG_EN
  ,
  output logic [7:0]              m_seq
`endif
);
  localparam int AW = DATA_WIDTH + AVG_LOG2_MAX;
  localparam int CW = AVG_LOG2_MAX + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ARM, WAIT_DATA, EMIT} state_t;
  state_t                   state_q;
  logic [PERIOD_WIDTH-1:0]  per_q, reload;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [2:0]               n_q, n_clamp;
  logic [TW-1:0]            tmo_q;
  logic                     tick, tmo_hit, last;
  assign reload  = (period < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(1) : period - PERIOD_WIDTH'(1);
  assign tick    = enable && per_q == '0;
  assign n_clamp = (avg_log2 > 3'(AVG_LOG2_MAX)) ? 3'(AVG_LOG2_MAX) : avg_log2;
  assign acc_d   = acc_q + {{AVG_LOG2_MAX{adc_data[DATA_WIDTH-1]}}, adc_data};
  assign cnt_d   = cnt_q + CW'(1);
  assign last    = cnt_d == (CW'(1) << n_q);
  assign tmo_hit = tmo_q == TW'(TIMEOUT_CYCLES - 1);
  assign busy    = state_q != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      per_q       <= reload;
      acc_q       <= '0;
      cnt_q       <= '0;
      n_q         <= '0;
      tmo_q       <= '0;
      adc_measure <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      timeout_err <= 1'b0;
      overrun_cnt <= '0;
`ifdef ADS_SCHED_SEQ_TAG_EN
      m_seq       <= '0;
`endif
    end else begin
      per_q       <= (!enable || per_q == '0) ? reload : per_q - PERIOD_WIDTH'(1);
      adc_measure <= 1'b0;
      if (tick && state_q != IDLE && overrun_cnt != 16'hFFFF) overrun_cnt <= overrun_cnt + 16'd1;
      if (m_valid && m_ready) m_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!enable) begin
            acc_q <= '0;
            cnt_q <= '0;
          end
          if (cnt_q == '0) n_q <= n_clamp;
          if (tick) begin
            state_q     <= ARM;
            adc_measure <= 1'b1;
          end
        end
        ARM: begin
          state_q <= WAIT_DATA;
          tmo_q   <= '0;
        end
        WAIT_DATA: begin
          // a sample landing on the final timeout cycle still counts
          if (adc_valid) begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            state_q <= last ? EMIT : IDLE;
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            acc_q       <= '0;
            cnt_q       <= '0;
            state_q     <= IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        default: begin
          if (!m_valid || m_ready) begin
            m_data  <= DATA_WIDTH'(acc_q >>> n_q);
            m_valid <= 1'b1;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
`ifdef ADS_SCHED_SEQ_TAG_EN
            m_seq   <= m_seq + 8'd1;
`endif
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ads1672_capture_sched.sv
// tb_ads1672_capture_sched: scoreboard bench for ads1672_capture_sched with a modelled ADC responder.
module tb_ads1672_capture_sched;
  localparam int DW  = 24;
  localparam int TMO = 16;
  logic          clk = 1'b0;
  logic          rst, enable, adc_valid, m_ready;
  logic [23:0]   period;
  logic [2:0]    avg_log2;
  logic          adc_measure, m_valid, busy, timeout_err;
  logic [DW-1:0] adc_data, m_data;
  logic [15:0]   overrun_cnt, ov0;
  logic [7:0]    m_seq;
  int            checks = 0, failures = 0;
  int            cyc = 0, m_last = 0, m_prev = 0, m_cnt = 0, v_last = 0, rx_cnt = 0, rst_gen = 0;
  int            resp_delay = 3, n_model = 0, mcnt = 0, m0, rx0;
  longint        msum = 0;
  bit            chk_lat = 0, pmv = 0, prdy = 0;
  logic [DW-1:0] last_rx = '0, pdata = '0, auto_v = 24'h000100;
  logic [DW-1:0] exp_q[$], smp_q[$];
  int            dly_q[$];

  ads1672_capture_sched #(.DATA_WIDTH(DW), .PERIOD_WIDTH(24), .TIMEOUT_CYCLES(TMO), .AVG_LOG2_MAX(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .avg_log2(avg_log2),
    .adc_measure(adc_measure), .adc_valid(adc_valid), .adc_data(adc_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy),
    .timeout_err(timeout_err), .overrun_cnt(overrun_cnt)
`ifdef ADS_SCHED_SEQ_TAG_EN
    , .m_seq(m_seq)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // expected result when block of 2^n samples completes; late or missing samples discard the block
  task automatic model(input logic [DW-1:0] s, input int d);
    longint q;
    if (d == 0 || d > TMO) begin
      msum = 0;
      mcnt = 0;
    end else begin
      msum += longint'(signed'(s));
      mcnt++;
      if (mcnt == (1 << n_model)) begin
        q = msum >>> n_model;
        exp_q.push_back(q[DW-1:0]);
        msum = 0;
        mcnt = 0;
      end
    end
  endtask

  initial begin
    int d, g;
    logic [DW-1:0] s;
    adc_valid = 1'b0;
    adc_data  = '0;
    forever begin
      @(negedge clk);
      if (adc_measure && !rst) begin
        d = (dly_q.size() > 0) ? dly_q.pop_front() : resp_delay;
        g = rst_gen;
        if (d > 0) begin
          if (smp_q.size() > 0) s = smp_q.pop_front();
          else begin
            s = auto_v;
            auto_v += 24'h000101;
          end
          repeat (d) @(posedge clk);
          #1;
          adc_valid = 1'b1;
          adc_data  = s;
          if (g == rst_gen) model(s, d);
          @(posedge clk);
          #1 adc_valid = 1'b0;
        end else if (g == rst_gen) model('0, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) pmv = 0;
    else begin
      if (adc_measure) begin
        m_prev = m_last;
        m_last = cyc;
        m_cnt++;
      end
      if (adc_valid) v_last = cyc;
      if (pmv && !prdy) begin
        chk("hold_data", m_data, pdata);
        chk("hold_valid", m_valid, 1);
      end
      if (chk_lat && m_valid && !pmv) chk("valid_latency", cyc - v_last, 2);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("sb_extra", exp_q.size(), 1);
        else begin
          chk("sb_data", m_data, exp_q.pop_front());
          last_rx = m_data;
          rx_cnt++;
        end
      end
      pmv   = m_valid;
      prdy  = m_ready;
      pdata = m_data;
    end
  end

  task automatic nsamp();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rx(input int k, input int bound);
    int target = rx_cnt + k;
    for (int i = 0; i < bound && rx_cnt < target; i++) nsamp();
    chk("rx_arrived", rx_cnt, target);
  endtask

  task automatic go();
    @(posedge clk);
    #1 enable = 1'b1;
  endtask

  task automatic stop();
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    msum = 0;
    mcnt = 0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; period = 24'd10; avg_log2 = 3'd0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    nsamp();
    chk("rst_measure", adc_measure, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_ovr", overrun_cnt, 0);

    chk_lat = 1;
    repeat (3) smp_q.push_back(24'h123456);
    go();
    wait_rx(3, 200);
    chk("basic_period", m_last - m_prev, 10);
    chk("basic_data", last_rx, 24'h123456);
    stop();

    avg_log2 = 3'd2; n_model = 2;
    smp_q.push_back(24'h000004); smp_q.push_back(24'hFFFFF8);
    smp_q.push_back(24'h000002); smp_q.push_back(24'hFFFFFF);
    go();
    wait_rx(1, 300);
    chk("avg_signed", last_rx, 24'hFFFFFF);
    stop();

    avg_log2 = 3'd7; n_model = 4;
    for (int i = 1; i <= 16; i++) smp_q.push_back(24'(i));
    go();
    wait_rx(1, 400);
    chk("avg_clamp", last_rx, 24'h000008);
    stop();
    chk_lat = 0;

    avg_log2 = 3'd0; n_model = 0; resp_delay = TMO;
    smp_q.push_back(24'h0ABCDE);
    go();
    wait_rx(1, 200);
    chk("tmo_edge_data", last_rx, 24'h0ABCDE);
    chk("tmo_edge_err", timeout_err, 0);
    stop();

    avg_log2 = 3'd1; n_model = 1; resp_delay = 3;
    dly_q.push_back(3); dly_q.push_back(0);
    smp_q.push_back(24'h000100); smp_q.push_back(24'h000010); smp_q.push_back(24'h000020);
    go();
    for (int i = 0; i < 200 && !timeout_err; i++) nsamp();
    chk("tmo_latency", cyc - m_last, 17);
    wait_rx(1, 200);
    chk("tmo_discard", last_rx, 24'h000018);
    chk("tmo_sticky", timeout_err, 1);
    stop();

    avg_log2 = 3'd0; n_model = 0; period = 24'd4; resp_delay = 9;
    go();
    wait_rx(1, 200);
    ov0 = overrun_cnt;
    wait_rx(1, 200);
    chk("ovr_delta", 32'(overrun_cnt - ov0), 2);
    chk("ovr_interval", m_last - m_prev, 12);
    stop();

    period = 24'd0; resp_delay = 1;
    go();
    wait_rx(1, 200);
    ov0 = overrun_cnt;
    wait_rx(1, 200);
    chk("pclamp_ovr", 32'(overrun_cnt - ov0), 1);
    chk("pclamp_interval", m_last - m_prev, 4);
    stop();

    period = 24'd10; resp_delay = 3;
    smp_q.push_back(24'h111111); smp_q.push_back(24'h222222); smp_q.push_back(24'h333333);
    ov0 = overrun_cnt;
    @(posedge clk);
    #1 m_ready = 1'b0; enable = 1'b1;
    repeat (40) @(posedge clk);
    nsamp();
    chk("bp_hold", m_data, 24'h111111);
    chk("bp_busy", busy, 1);
    chk("bp_ovr", overrun_cnt > ov0, 1);
    @(posedge clk);
    #1 m_ready = 1'b1;
    wait_rx(2, 100);
    chk("bp_second", last_rx, 24'h222222);
    stop();

    resp_delay = 10; m0 = m_cnt;
    go();
    for (int i = 0; i < 100 && m_cnt == m0; i++) nsamp();
    chk("rst_armed", m_cnt, m0 + 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; enable = 1'b0; rst_gen++;
    @(posedge clk);
    #1 rst = 1'b0;
    nsamp();
    rx0 = rx_cnt;
    chk("mrst_measure", adc_measure, 0);
    chk("mrst_valid", m_valid, 0);
    chk("mrst_data", m_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_tmo", timeout_err, 0);
    chk("mrst_ovr", overrun_cnt, 0);
    repeat (15) nsamp();
    chk("mrst_ign_busy", busy, 0);
    chk("mrst_ign_valid", m_valid, 0);
    chk("mrst_ign_rx", rx_cnt, rx0);
    chk("mrst_ign_ovr", overrun_cnt, 0);
    msum = 0; mcnt = 0;

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end
endmodule
